inbuf_frame_ctrl: RTL and testbench

Frame-level sequencer and arbiter for the single-port input pixel BRAM shared by a frame loader (write requester) and the 3x3 window reader (read requester).
- Sequences each frame: load DEPTH pixels, then run the window generator until a full frame of windows has been emitted.
- Owns the BRAM port mux and gates the window block's pixel-rate enable.
- Sits between the stream source, the input memory wrapper and the window generator inside the CNN top.

---
 rtl/inbuf_frame_ctrl.sv | 169 ++++++++++++++++
 tb/tb_inbuf_frame_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inbuf_frame_ctrl.sv
// Frame sequencer and port arbiter for the shared input pixel BRAM.
// Optional watchdog: define INBUF_WATCHDOG_EN to build the RUN-state timeout.
module inbuf_frame_ctrl #(
  parameter int DATA_W  = 24,
  parameter int ADDR_W  = 17,
  parameter int DEPTH   = 130560,
  parameter int WIN_CNT = 129060,
  parameter int TIMEOUT = 4096
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iWrValid,
  input  logic [DATA_W-1:0] iWrData,
  output logic              oWrReady,
  input  logic              iTickEn,
  output logic              oWinEn,
  output logic              oWinClr,
  input  logic              iRdCs,
  input  logic [ADDR_W-1:0] iRdAddr,
  input  logic              iWinValid,
  output logic              oBramEn,
  output logic              oBramWe,
  output logic [ADDR_W-1:0] oBramAddr,
  output logic [DATA_W-1:0] oBramDin,
  output logic              oBusy,
  output logic              oFrameDone,
  output logic              oErr,
  output logic [1:0]        oState
);

  localparam int PtrW = $clog2(DEPTH + 1);
  localparam int CntW = $clog2(WIN_CNT + 1);

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Load = 2'd1,
    Run  = 2'd2
  } state_t;

  state_t          state;
  logic [PtrW-1:0] wrPtr;
  logic [CntW-1:0] winCnt;
  logic            frameDone;
  logic            winClr;
  logic            err;

  logic            inLoad;
  logic            inRun;
  logic            wrXfer;
  logic            lastPix;
  logic            lastWin;
  logic            wdTrip;

  assign inLoad  = (state == Load);
  assign inRun   = (state == Run);
  assign wrXfer  = inLoad & iWrValid;
  assign lastPix = wrXfer & (wrPtr == PtrW'(DEPTH - 1));
  assign lastWin = inRun & iWinValid
                 & (winCnt == CntW'(WIN_CNT - 1));

`ifdef INBUF_WATCHDOG_EN
  localparam int WdW = $clog2(TIMEOUT + 1);

  logic [WdW-1:0] wdCnt;

  assign wdTrip = inRun & ~iWinValid
                & (wdCnt == WdW'(TIMEOUT - 1));

  // Idle-cycle counter, live only in RUN, reset by window progress
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      wdCnt <= '0;
    end else if (!inRun || iWinValid) begin
      wdCnt <= '0;
    end else begin
      wdCnt <= wdCnt + 1'b1;
    end
  end
`else
  // Never trips: RUN waits indefinitely for the window stream
  assign wdTrip = (TIMEOUT < 0);
`endif

  // Frame state machine with pointer, window count and status pulses
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state     <= Idle;
      wrPtr     <= '0;
      winCnt    <= '0;
      frameDone <= 1'b0;
      winClr    <= 1'b0;
      err       <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      winClr    <= 1'b0;
      case (state)
        Idle: begin
          if (iStart) begin
            state  <= Load;
            wrPtr  <= '0;
            winCnt <= '0;
            err    <= 1'b0;
          end
        end
        Load: begin
          if (wrXfer) begin
            wrPtr <= wrPtr + 1'b1;
          end
          if (lastPix) begin
            state  <= Run;
            winClr <= 1'b1;
            winCnt <= '0;
          end
        end
        Run: begin
          if (wdTrip) begin
            state  <= Idle;
            winCnt <= '0;
            err    <= 1'b1;
          end else if (lastWin) begin
            state     <= Idle;
            winCnt    <= '0;
            frameDone <= 1'b1;
          end else if (iWinValid) begin
            winCnt <= winCnt + 1'b1;
          end
        end
        default: begin
          state <= Idle;
        end
      endcase
    end
  end

  // Port mux and window enable decoded from the registered state
  always_comb begin
    oWrReady  = 1'b0;
    oWinEn    = 1'b0;
    oBramEn   = 1'b0;
    oBramWe   = 1'b0;
    oBramAddr = '0;
    oBramDin  = '0;
    case (state)
      Load: begin
        oWrReady  = 1'b1;
        oBramEn   = iWrValid;
        oBramWe   = 1'b1;
        oBramAddr = ADDR_W'(wrPtr);
        oBramDin  = iWrData;
      end
      Run: begin
        oWinEn    = iTickEn & ~winClr;
        oBramEn   = iRdCs;
        oBramAddr = iRdAddr;
      end
      default: begin
        oWrReady = 1'b0;
      end
    endcase
  end

  assign oWinClr    = winClr;
  assign oFrameDone = frameDone;
  assign oErr       = err;
  assign oState     = state;
  assign oBusy      = (state != Idle);

endmodule

// File: tb/tb_inbuf_frame_ctrl.sv
// Directed bench for inbuf_frame_ctrl with write and done scoreboards.
// Define INBUF_WATCHDOG_EN for both files to exercise the timeout.
module tb_inbuf_frame_ctrl;

  localparam int DW    = 24;
  localparam int AW    = 17;
  localparam int DEPTH = 40;
  localparam int WIN   = 30;
  localparam int TO    = 16;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iStart;
  logic          iWrValid;
  logic [DW-1:0] iWrData;
  logic          oWrReady;
  logic          iTickEn;
  logic          oWinEn;
  logic          oWinClr;
  logic          iRdCs;
  logic [AW-1:0] iRdAddr;
  logic          iWinValid;
  logic          oBramEn;
  logic          oBramWe;
  logic [AW-1:0] oBramAddr;
  logic [DW-1:0] oBramDin;
  logic          oBusy;
  logic          oFrameDone;
  logic          oErr;
  logic [1:0]    oState;

  inbuf_frame_ctrl #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DEPTH),
    .WIN_CNT(WIN),
    .TIMEOUT(TO)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iStart    (iStart),
    .iWrValid  (iWrValid),
    .iWrData   (iWrData),
    .oWrReady  (oWrReady),
    .iTickEn   (iTickEn),
    .oWinEn    (oWinEn),
    .oWinClr   (oWinClr),
    .iRdCs     (iRdCs),
    .iRdAddr   (iRdAddr),
    .iWinValid (iWinValid),
    .oBramEn   (oBramEn),
    .oBramWe   (oBramWe),
    .oBramAddr (oBramAddr),
    .oBramDin  (oBramDin),
    .oBusy     (oBusy),
    .oFrameDone(oFrameDone),
    .oErr      (oErr),
    .oState    (oState)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t  wrQ[$];
  logic doneQ[$];
  int   checks = 0;
  int   errors = 0;
  int   wp     = 0;
  int   cyc    = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic samp();
    @(negedge iClk);
  endtask

  // Streams n pixels with a gap every third cycle; starts at posedge+1
  task automatic writePix(input int n, input int startAt);
    int  issued;
    int  guard;
    wr_t w;
    issued = 0;
    guard  = 0;
    while (issued < n && guard < 1000) begin
      guard++;
      iWrValid = (cyc % 3 != 2);
      cyc++;
      iStart = iWrValid && (wp == startAt);
      if (iWrValid) begin
        iWrData = DW'($urandom);
        wrQ.push_back('{AW'(wp), iWrData});
        wp++;
        issued++;
      end
      samp();
      chk("load_state", 32'(oState), 32'd1);
      chk("load_en", 32'(oBramEn), 32'(iWrValid));
      if (oBramEn && oBramWe) begin
        chk("wr_q", wrQ.size(), 32'd1);
        if (wrQ.size() > 0) begin
          w = wrQ.pop_front();
          chk("wr_addr", 32'(oBramAddr), 32'(w.addr));
          chk("wr_data", 32'(oBramDin), 32'(w.data));
        end
      end
      tick();
    end
    chk("load_count", issued, n);
    iWrValid = 1'b0;
    iStart   = 1'b0;
    chk("wr_q_empty", wrQ.size(), 32'd0);
  endtask

  initial begin
    int  n;
    int  k;
    logic e;
    iRst      = 1'b0;
    iStart    = 1'b0;
    iWrValid  = 1'b0;
    iWrData   = '0;
    iTickEn   = 1'b0;
    iRdCs     = 1'b0;
    iRdAddr   = '0;
    iWinValid = 1'b0;

    samp();
    chk("rst_state", 32'(oState), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_done", 32'(oFrameDone), 32'd0);
    chk("rst_err", 32'(oErr), 32'd0);
    chk("rst_clr", 32'(oWinClr), 32'd0);
    chk("rst_bram", 32'(oBramEn), 32'd0);
    chk("rst_rdy", 32'(oWrReady), 32'd0);
    tick();
    iRst    = 1'b1;
    iTickEn = 1'b1;
    tick();

    iStart = 1'b1;
    samp();
    chk("idle_state", 32'(oState), 32'd0);
    tick();
    iStart = 1'b0;
    samp();
    chk("start_state", 32'(oState), 32'd1);
    chk("start_rdy", 32'(oWrReady), 32'd1);
    chk("start_bram", 32'(oBramEn), 32'd0);
    chk("start_winen", 32'(oWinEn), 32'd0);
    tick();

    wp  = 0;
    cyc = 0;
    writePix(DEPTH, -1);
    samp();
    chk("run_state", 32'(oState), 32'd2);
    chk("run_clr", 32'(oWinClr), 32'd1);
    chk("run_winen_clr", 32'(oWinEn), 32'd0);
    chk("run_rdy", 32'(oWrReady), 32'd0);
    tick();
    iTickEn = 1'b0;
    samp();
    chk("clr_once", 32'(oWinClr), 32'd0);
    chk("winen_off", 32'(oWinEn), 32'd0);
    iTickEn = 1'b1;
    #1;
    chk("winen_on", 32'(oWinEn), 32'd1);
    tick();

    iRdCs    = 1'b1;
    iRdAddr  = 17'h00123;
    iWrValid = 1'b1;
    iStart   = 1'b1;
    samp();
    chk("rd_en", 32'(oBramEn), 32'd1);
    chk("rd_we", 32'(oBramWe), 32'd0);
    chk("rd_addr", 32'(oBramAddr), 32'h123);
    chk("rd_din", 32'(oBramDin), 32'd0);
    tick();
    iStart   = 1'b0;
    iWrValid = 1'b0;
    iRdCs    = 1'b0;
    samp();
    chk("run_start_ign", 32'(oState), 32'd2);
    chk("rd_idle", 32'(oBramEn), 32'd0);
    tick();

    n = 0;
    k = 0;
    while (n < WIN && k < 400) begin
      iWinValid = (k % 2 == 0);
      k++;
      samp();
      if (doneQ.size() > 0) begin
        e = doneQ.pop_front();
        chk("done_seq", 32'(oFrameDone), 32'(e));
      end
      chk("win_state", 32'(oState), 32'd2);
      doneQ.push_back(iWinValid && n == WIN - 1);
      if (iWinValid) n++;
      tick();
    end
    chk("win_count", n, WIN);
    iWinValid = 1'b0;
    samp();
    if (doneQ.size() > 0) begin
      e = doneQ.pop_front();
      chk("done_last", 32'(oFrameDone), 32'(e));
    end
    chk("done_q", doneQ.size(), 32'd0);
    chk("done_state", 32'(oState), 32'd0);
    chk("done_busy", 32'(oBusy), 32'd0);
    iStart = 1'b1;
    tick();
    iStart    = 1'b0;
    iWinValid = 1'b1;
    samp();
    chk("done_pulse1", 32'(oFrameDone), 32'd0);
    chk("start_on_done", 32'(oState), 32'd1);
    tick();
    iWinValid = 1'b0;

    wp  = 0;
    cyc = 0;
    writePix(20, 10);
    iWrValid = 1'b1;
    samp();
    chk("mid_start_ign", 32'(oState), 32'd1);
    #2;
    iRst = 1'b0;
    #1;
    chk("arst_state", 32'(oState), 32'd0);
    chk("arst_busy", 32'(oBusy), 32'd0);
    chk("arst_rdy", 32'(oWrReady), 32'd0);
    chk("arst_bram", 32'(oBramEn), 32'd0);
    chk("arst_done", 32'(oFrameDone), 32'd0);
    iWrValid = 1'b0;
    tick();
    iRst = 1'b1;
    tick();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    wp  = 0;
    cyc = 0;
    writePix(3, -1);
    writePix(DEPTH - 3, -1);
    samp();
    chk("wd_run", 32'(oState), 32'd2);
    chk("wd_err0", 32'(oErr), 32'd0);

`ifdef INBUF_WATCHDOG_EN
    for (int i = 1; i <= TO; i++) begin
      tick();
      samp();
      chk("wd_err", 32'(oErr), 32'(i == TO));
      chk("wd_state", 32'(oState), (i == TO) ? 32'd0 : 32'd2);
      chk("wd_nodone", 32'(oFrameDone), 32'd0);
    end
    tick();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    samp();
    chk("wd_clear", 32'(oErr), 32'd0);
    chk("wd_restart", 32'(oState), 32'd1);
`else
    for (int i = 1; i <= TO + 4; i++) begin
      tick();
      samp();
      chk("nowd_state", 32'(oState), 32'd2);
      chk("nowd_err", 32'(oErr), 32'd0);
    end
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
